// File: rtl/estat_timer_int_pkg.sv
// estat_timer_int_pkg: shared ESTAT/TCFG field positions and masks
package estat_timer_int_pkg;
  localparam int IS_SWI0 = 0;
  localparam int IS_SWI1 = 1;
  localparam int IS_HWI_LO = 2;
  localparam int IS_HWI_HI = 9;
  localparam int IS_RSV = 10;
  localparam int IS_TI = 11;
  localparam int IS_IPI = 12;
  localparam int TCFG_EN = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TCFG_INITVAL_LO = 2;
  localparam logic [12:0] LIE_MASK = 13'h1BFF;
  typedef logic [12:0] estat_is_t;
endpackage

// File: rtl/estat_timer_int_sync.sv
// csr_sync_chain: multi-stage synchroniser for asynchronous level inputs
module csr_sync_chain #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] ff;
  // shift the input through STAGES flops; the oldest stage is the output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/estat_timer_int.sv
// estat_timer_int: ESTAT.IS owner, constant timer and registered interrupt request
module estat_timer_int
  import estat_timer_int_pkg::*;
#(
  parameter int TIMER_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [12:0]            ECFG_LIE,
  input  logic                   CRMD_IE,
  input  logic                   CSRWR_ESTAT_EN,
  input  logic [1:0]             CSRWR_ESTAT_data,
  input  logic                   CSRWR_TCFG_EN,
  input  logic [TIMER_WIDTH-1:0] CSRWR_TCFG_data,
  input  logic                   CSRWR_TICLR_EN,
  input  logic                   CSRWR_TICLR_data,
  input  logic [7:0]             hwi_in,
  input  logic                   ipi_in,
  input  logic                   int_ack,
  output logic [12:0]            ESTAT_IS,
  output logic [TIMER_WIDTH-1:0] TCFG,
  output logic [TIMER_WIDTH-1:0] TVAL,
  output logic                   int_req
);
  logic [1:0] swi;
  logic [7:0] hwi_s;
  logic ipi_q, ti, armed, ack_block, tick, expire;
  logic [TIMER_WIDTH-1:0] reload;
  csr_sync_chain #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_hwi_sync (
    .clk(clk), .rst_n(rst_n), .d(hwi_in), .q(hwi_s)
  );
  assign reload = {TCFG[TIMER_WIDTH-1:TCFG_INITVAL_LO], 2'b00};
  assign tick = ~CSRWR_TCFG_EN & TCFG[TCFG_EN] & armed;
  assign expire = tick & (TVAL == '0);
  assign ESTAT_IS = {ipi_q, ti, 1'b0, hwi_s, swi};
  // software interrupt bits and the once-registered IPI level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      swi <= '0;
      ipi_q <= 1'b0;
    end else begin
      if (CSRWR_ESTAT_EN) swi <= CSRWR_ESTAT_data;
      ipi_q <= ipi_in;
    end
  // timer: a TCFG write overrides any tick; expiry reloads or disarms
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      TCFG <= '0;
      TVAL <= '0;
      armed <= 1'b0;
    end else if (CSRWR_TCFG_EN) begin
      TCFG <= CSRWR_TCFG_data;
      TVAL <= {CSRWR_TCFG_data[TIMER_WIDTH-1:TCFG_INITVAL_LO], 2'b00};
      armed <= CSRWR_TCFG_data[TCFG_EN];
    end else if (tick) begin
      TVAL <= expire ? (TCFG[TCFG_PERIODIC] ? reload : TVAL) : TVAL - TIMER_WIDTH'(1);
      armed <= ~expire | TCFG[TCFG_PERIODIC];
    end
  // timer interrupt flag: expiry set beats a simultaneous TICLR clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ti <= 1'b0;
    else if (expire) ti <= 1'b1;
    else if (CSRWR_TICLR_EN && CSRWR_TICLR_data) ti <= 1'b0;
  // registered request, suppressed for one cycle after the commit acknowledge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      int_req <= 1'b0;
      ack_block <= 1'b0;
    end else begin
      int_req <= CRMD_IE & |(ECFG_LIE & LIE_MASK & ESTAT_IS) & ~ack_block;
      ack_block <= int_ack;
    end
endmodule

// File: doc/estat_timer_int.md
Name: estat_timer_int

Overview:
- Consumer side of the ECFG CSR. It owns ESTAT.IS[12:0], the constant timer (TCFG/TVAL) and the TICLR clear path.
- Each cycle it ANDs ESTAT.IS with ECFG.LIE[12:0] and CRMD.IE to produce a registered interrupt request.
- The request goes to the commit stage, which acknowledges it when it takes the interrupt.
- Sits beside the CSR file; its ESTAT/TCFG/TVAL outputs feed CSRRD muxing.

Parameters:
- TIMER_WIDTH, 32, width of TVAL and TCFG (InitVal = TCFG[TIMER_WIDTH-1:2]).
- SYNC_STAGES, 2, flop stages on each asynchronous hwi_in bit (minimum 2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ECFG_LIE  in  13  ECFG[12:0]; bit 10 is reserved and always 0
- CRMD_IE  in  1  global interrupt enable
- CSRWR_ESTAT_EN  in  1  ESTAT write strobe
- CSRWR_ESTAT_data  in  2  new SWI[1:0]
- CSRWR_TCFG_EN  in  1  TCFG write strobe
- CSRWR_TCFG_data  in  TIMER_WIDTH  new TCFG value
- CSRWR_TICLR_EN  in  1  TICLR write strobe
- CSRWR_TICLR_data  in  1  TICLR.CLR bit
- hwi_in  in  8  asynchronous hardware interrupt lines
- ipi_in  in  1  inter-processor interrupt level, synchronous to clk
- int_ack  in  1  one-cycle pulse: commit has taken the interrupt
- ESTAT_IS  out  13  {IPI, TI, 1'b0, HWI[7:0], SWI[1:0]}
- TCFG  out  TIMER_WIDTH  {InitVal, Periodic, En}
- TVAL  out  TIMER_WIDTH  current timer count
- int_req  out  1  registered interrupt request level

Behaviour:
- Reset (async, rst_n low): every register cleared. ESTAT_IS = 0, TCFG = 0, TVAL = 0, int_req = 0, armed = 0, sync chains = 0, ack_block = 0.
- SWI[1:0]:
  - Loaded from CSRWR_ESTAT_data on CSRWR_ESTAT_EN.
  - Visible on ESTAT_IS the next cycle.
  - Only software changes them.
- HWI[7:0]:
  - Each bit passes through SYNC_STAGES flops.
  - IS[9:2] equals the last sync stage, so it is level-sensitive and not latched.
  - An hwi_in change reaches ESTAT_IS SYNC_STAGES cycles after the first capturing edge.
- IPI (IS[12]): ipi_in registered once and level-sensitive.
- IS[10]: constant 0.
- TCFG write:
  - TCFG <= data.
  - TVAL <= {data[TIMER_WIDTH-1:2], 2'b00}.
  - armed <= data[0].
- Timer tick, in any cycle with no TCFG write, TCFG.En = 1 and armed = 1:
  - If TVAL != 0: TVAL decrements by 1.
  - If TVAL == 0: expiry. TI <= 1. If Periodic, TVAL reloads {InitVal, 2'b00} and stays armed; otherwise armed <= 0 and TVAL holds 0.
  - Periodic with InitVal = 0 therefore expires every cycle.
- Disarmed or En = 0: TVAL holds its value.
- TI clear: CSRWR_TICLR_EN with data = 1 clears TI. TICLR data = 0 has no effect.
- Collisions:
  - Expiry and TICLR clear in the same cycle: the set wins (TI = 1).
  - TCFG write and expiry in the same cycle: the write wins, and TI is not set.
  - TCFG write does not modify TI.
- Interrupt request:
  - Next cycle: int_req <= CRMD_IE & |(ECFG_LIE & ESTAT_IS) & ~ack_block.
  - Latency is 1 cycle from any ESTAT_IS, LIE or IE change.
- Acknowledge:
  - int_ack sets ack_block for exactly the next cycle, so int_req is 0 in the cycle after the one following int_ack.
  - This covers the CRMD.IE clear propagating from exception entry.
  - int_ack while int_req = 0 is ignored apart from ack_block.
- Reset mid-count: the timer is immediately disarmed, all state goes to 0, and there is no spurious TI.

Decomposition:
- Shared CSR package holds:
  - IS bit indices: SWI0 = 0, SWI1 = 1, HWI_LO = 2, HWI_HI = 9, RSV = 10, TI = 11, IPI = 12.
  - TCFG field positions: EN = 0, PERIODIC = 1, INITVAL_LO = 2.
  - LIE_MASK = 13'h1BFF.
- One natural sub-module: csr_sync_chain, a parameterised SYNC_STAGES-deep synchroniser, instantiated 8 wide for hwi_in.

Test Plan:
- Reset: assert rst_n = 0 mid-count with TVAL = 0x20, TI = 1 -> all outputs 0 asynchronously; after release TVAL stays 0 with no tick.
- HWI path: hwi_in[3] 0->1 with LIE = 0x0020, IE = 1 -> ESTAT_IS[5] rises 2 cycles later and int_req 1 cycle after that. Repeat with LIE bit 5 = 0 or IE = 0 -> int_req stays 0.
- One-shot timer: TCFG write 0x0000_0009 (InitVal = 2, En = 1) -> TVAL 8, 7, …, 0; TI = 1 on the cycle after TVAL = 0; TVAL holds 0; no further expiry.
- Periodic timer: TCFG = 0x0000_0007 (InitVal = 1, Periodic) -> TVAL 4, 3, 2, 1, 0, 4, … with TI set at each zero. TICLR = 1 between expiries clears TI; TICLR coinciding with expiry leaves TI = 1.
- Collision: TCFG rewrite in the same cycle TVAL = 0 -> no TI set and TVAL reloads from the new InitVal.
- Ack handshake: SWI0 set with LIE = 1, IE = 1 -> int_req = 1. Pulse int_ack -> int_req = 0 for one cycle, then 1 again while IS & LIE & IE remains nonzero.
